// File: rtl/servo_pkg.sv
// servo_pkg: shared definitions for the servo PWM peripheral.
//   - register word offsets relative to BASE_ADDR
//   - FSM state encoding
//   - pulse-width type and the write-clamp helper
package servo_pkg;

    typedef logic [15:0] width_t;

    localparam logic [1:0] REG_TARGET = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Clamp a software-supplied width into the legal [lo, hi] range.
    function automatic width_t clamp_width(input width_t w, input width_t lo, input width_t hi);
        if (w < lo)      return lo;
        else if (w > hi) return hi;
        else             return w;
    endfunction

endpackage

// File: rtl/servo_timebase.sv
// servo_timebase: microsecond prescaler plus in-period microsecond counter.
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   en_i          run enable; while low both counters are held at 0
//   us_cnt_o      microseconds elapsed in the current period (0..PERIOD_US-1)
//   period_end_o  high on the cycle us_cnt wraps PERIOD_US-1 -> 0
module servo_timebase
    import servo_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int PERIOD_US = 20000
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   en_i,
    output width_t us_cnt_o,
    output logic   period_end_o
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = $clog2(DIV);

    logic [PW-1:0] presc_q;
    width_t        us_cnt_q;
    logic          us_tick;

    assign us_tick      = en_i && (presc_q == PW'(DIV - 1));
    assign period_end_o = us_tick && (us_cnt_q == width_t'(PERIOD_US - 1));
    assign us_cnt_o     = us_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q  <= '0;
            us_cnt_q <= '0;
        end else if (!en_i) begin
            presc_q  <= '0;
            us_cnt_q <= '0;
        end else begin
            presc_q <= us_tick ? '0 : presc_q + 1'b1;
            if (us_tick)
                us_cnt_q <= period_end_o ? '0 : us_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/servo_pwm_mmio.sv
// servo_pwm_mmio: memory-mapped 50 Hz servo PWM with slew-limited width tracking.
// Ports:
//   clock    system clock
//   reset    asynchronous active-low reset
//   wEn      dmem write enable
//   addr     dmem word address
//   dataIn   dmem write data
//   rdata    read data for BASE..BASE+2, 0 otherwise (combinational)
//   rhit     addr decodes to BASE..BASE+2 (combinational)
//   pwm_out  registered servo pulse
//   busy     width still tracking toward target while enabled
// Register map (word offsets from BASE_ADDR):
//   0 TARGET  [15:0] width in us, clamped to [MIN_US, MAX_US] on write
//   1 CTRL    [0] enable
//   2 STATUS  {busy, 15'b0, cur_width[15:0]}, read only
module servo_pwm_mmio
    import servo_pkg::*;
#(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          PERIOD_US = 20000,
    parameter int          MIN_US    = 1000,
    parameter int          MAX_US    = 2000,
    parameter int          SLEW_US   = 10,
    parameter logic [11:0] BASE_ADDR = 12'd8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wEn,
    input  logic [11:0] addr,
    input  logic [31:0] dataIn,
    output logic [31:0] rdata,
    output logic        rhit,
    output logic        pwm_out,
    output logic        busy
);

    localparam width_t           MIN_W  = width_t'(MIN_US);
    localparam width_t           MAX_W  = width_t'(MAX_US);
    localparam width_t           MID_W  = width_t'((MIN_US + MAX_US) / 2);
    localparam width_t           SLEW_W = width_t'(SLEW_US);
    localparam logic signed [16:0] SLEW_S = 17'(SLEW_US);

    width_t      target_q, target_d;
    width_t      cur_q, cur_d, cur_step;
    logic        enable_q, enable_d;
    logic        pwm_q, pwm_d;
    state_e      state_q;

    logic [11:0] off;
    logic        wr_target, wr_ctrl;
    logic        run;
    width_t      us_cnt;
    logic        period_end;
    logic signed [16:0] diff;
    logic        unused_data;

    assign unused_data = ^dataIn[31:16];

    // ---------------- decode ----------------
    assign off       = addr - BASE_ADDR;
    assign rhit      = (off < 12'd3);
    assign wr_target = wEn && rhit && (off[1:0] == REG_TARGET);
    assign wr_ctrl   = wEn && rhit && (off[1:0] == REG_CTRL);

    always_comb begin
        rdata = '0;
        if (rhit) begin
            case (off[1:0])
                REG_TARGET: rdata = {16'b0, target_q};
                REG_CTRL:   rdata = {31'b0, enable_q};
                REG_STATUS: rdata = {busy, 15'b0, cur_q};
                default:    rdata = '0;
            endcase
        end
    end

    // Counting only runs when enabled both before and after this edge: a
    // disabling write clears the counters and the pulse on its own edge, and
    // an enabling write starts the period cleanly from us_cnt=0 one edge later.
    assign run = enable_q && enable_d;

    servo_timebase #(
        .CLK_HZ    (CLK_HZ),
        .PERIOD_US (PERIOD_US)
    ) u_timebase (
        .clk_i        (clock),
        .rst_ni       (reset),
        .en_i         (run),
        .us_cnt_o     (us_cnt),
        .period_end_o (period_end)
    );

    // ---------------- slew ----------------
    // Uses target_q, so a target written on the period_end edge only affects
    // the following period.
    always_comb begin
        diff = $signed({1'b0, target_q}) - $signed({1'b0, cur_q});
        if (diff > SLEW_S)       cur_step = cur_q + SLEW_W;
        else if (diff < -SLEW_S) cur_step = cur_q - SLEW_W;
        else                     cur_step = target_q;
    end

    always_comb begin
        target_d = target_q;
        if (wr_target) target_d = clamp_width(dataIn[15:0], MIN_W, MAX_W);
        enable_d = enable_q;
        if (wr_ctrl) enable_d = dataIn[0];
        cur_d = cur_q;
        if (period_end) cur_d = cur_step;
        pwm_d = run && (us_cnt < cur_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            target_q <= MID_W;
            cur_q    <= MID_W;
            enable_q <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            cur_q    <= cur_d;
            enable_q <= enable_d;
            pwm_q    <= pwm_d;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else if (!enable_d) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    state_q <= (target_d != cur_d) ? TRACK : HOLD;
                TRACK:   if (period_end && (cur_d == target_d)) state_q <= HOLD;
                HOLD:    if (wr_target && (target_d != cur_d)) state_q <= TRACK;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q == TRACK);
    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_servo_pwm_mmio.sv
// tb_servo_pwm_mmio: directed bench for servo_pwm_mmio with a 4-clock
// microsecond, 100 us period and a 10..50 us legal width range.
module tb_servo_pwm_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        wEn;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic [31:0] rdata;
    logic        rhit;
    logic        pwm_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servo_pwm_mmio #(
        .CLK_HZ    (4_000_000),
        .PERIOD_US (100),
        .MIN_US    (10),
        .MAX_US    (50),
        .SLEW_US   (5),
        .BASE_ADDR (12'd8)
    ) dut (
        .clock   (clk),
        .reset   (reset),
        .wEn     (wEn),
        .addr    (addr),
        .dataIn  (dataIn),
        .rdata   (rdata),
        .rhit    (rhit),
        .pwm_out (pwm_out),
        .busy    (busy)
    );

    typedef struct {
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [11:0] ra;
        logic [31:0] exp_rdata;
        logic        exp_rhit;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", nm, act, act, exp, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    // Called at a negedge; write lands on the next posedge; returns at the following negedge.
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wEn = 1'b1; addr = a; dataIn = d;
        @(negedge clk);
        wEn = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(nm, rdata, exp);
    endtask

    task automatic wait_rise(input string nm);
        logic prev;
        bit   found;
        prev  = pwm_out;
        found = 0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (!prev && pwm_out) found = 1;
            prev = pwm_out;
        end
        if (!found) fail(nm);
    endtask

    // Width in clocks of the next pulse; returns at its first low sample.
    task automatic measure_pulse(input string nm, output int hi);
        hi = 0;
        wait_rise(nm);
        if (!pwm_out) return;
        hi = 1;
        for (int n = 0; n < 1000 && pwm_out; n++) begin
            @(negedge clk);
            if (pwm_out) hi++;
        end
    endtask

    // Low time from the current (first low) sample to the next rise, then skip that pulse.
    task automatic measure_gap(output int lo);
        lo = 1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (pwm_out) break;
            lo++;
        end
        for (int n = 0; n < 1000 && pwm_out; n++) @(negedge clk);
    endtask

    int w;

    initial begin
        vecs[0]  = '{0, 12'd0,  32'd0,      12'd8,  32'd30,         1'b1};
        vecs[1]  = '{0, 12'd0,  32'd0,      12'd9,  32'd0,          1'b1};
        vecs[2]  = '{0, 12'd0,  32'd0,      12'd10, 32'd30,         1'b1};
        vecs[3]  = '{0, 12'd0,  32'd0,      12'd11, 32'd0,          1'b0};
        vecs[4]  = '{0, 12'd0,  32'd0,      12'd7,  32'd0,          1'b0};
        vecs[5]  = '{1, 12'd8,  32'd3,      12'd8,  32'd10,         1'b1};
        vecs[6]  = '{1, 12'd8,  32'd900,    12'd8,  32'd50,         1'b1};
        vecs[7]  = '{1, 12'd8,  32'd0,      12'd8,  32'd10,         1'b1};
        vecs[8]  = '{1, 12'd8,  32'd17,     12'd8,  32'd17,         1'b1};
        vecs[9]  = '{1, 12'd10, 32'hFFFF,   12'd10, 32'd30,         1'b1};
        vecs[10] = '{1, 12'd9,  32'd2,      12'd9,  32'd0,          1'b1};
        vecs[11] = '{1, 12'd8,  32'd30,     12'd8,  32'd30,         1'b1};
        vecs[12] = '{1, 12'd11, 32'd5,      12'd8,  32'd30,         1'b1};
        vecs[13] = '{0, 12'd0,  32'd0,      12'd10, 32'd30,         1'b1};

        reset = 1'b0; wEn = 1'b0; addr = '0; dataIn = '0;
        repeat (3) @(negedge clk);
        chk("reset pwm", {31'b0, pwm_out}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Register access while disabled: clamp, read-only STATUS, decode range.
        for (int i = 0; i < 14; i++) begin
            wEn = vecs[i].we; addr = vecs[i].wa; dataIn = vecs[i].wd;
            @(negedge clk);
            wEn = 1'b0; addr = vecs[i].ra;
            #1;
            chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d rhit", i), {31'b0, rhit}, {31'b0, vecs[i].exp_rhit});
        end

        // Enable with target == cur: steady 30 us pulse every 100 us.
        @(negedge clk);
        wr(12'd9, 32'd1);
        chk("enable busy", {31'b0, busy}, 32'd0);
        measure_pulse("pulse30", w);  chk("pulse30 clocks", w, 120);
        measure_gap(w);               chk("gap30 clocks", w, 280);

        // Slew up 30 -> 45.
        wr(12'd8, 32'd45);
        chk("track busy", {31'b0, busy}, 32'd1);
        measure_pulse("up35", w);     chk("up35 clocks", w, 140);
        measure_pulse("up40", w);     chk("up40 clocks", w, 160);
        chk("mid-track busy", {31'b0, busy}, 32'd1);
        measure_pulse("up45", w);     chk("up45 clocks", w, 180);
        chk("settled busy", {31'b0, busy}, 32'd0);

        // Clamped writes, stepping down then up.
        wr(12'd8, 32'd3);
        rd_chk("target clamp low", 12'd8, 32'd10);
        measure_pulse("dn40", w);     chk("dn40 clocks", w, 160);
        measure_pulse("dn35", w);     chk("dn35 clocks", w, 140);
        wr(12'd8, 32'd900);
        rd_chk("target clamp high", 12'd8, 32'd50);
        measure_pulse("rise40", w);   chk("rise40 clocks", w, 160);
        measure_pulse("rise45", w);   chk("rise45 clocks", w, 180);
        measure_pulse("rise50", w);   chk("rise50 clocks", w, 200);
        chk("at max busy", {31'b0, busy}, 32'd0);

        // Target write landing exactly on the period_end edge (width 50 -> edge 198 negedges on).
        repeat (198) @(negedge clk);
        wr(12'd8, 32'd20);
        chk("pe write busy", {31'b0, busy}, 32'd1);
        rd_chk("pe write status", 12'd10, 32'h8000_0032);
        measure_pulse("pe old", w);   chk("pe old target clocks", w, 200);
        measure_pulse("pe new", w);   chk("pe new target clocks", w, 180);

        // Disable mid-pulse (width has stepped to 40 at the period_end before this rise).
        wait_rise("pre-disable");
        repeat (20) @(negedge clk);
        chk("mid-pulse pwm", {31'b0, pwm_out}, 32'd1);
        wr(12'd9, 32'd0);
        chk("disable pwm", {31'b0, pwm_out}, 32'd0);
        chk("disable us_cnt", {16'b0, dut.us_cnt}, 32'd0);
        chk("disable busy", {31'b0, busy}, 32'd0);
        repeat (600) @(negedge clk);
        chk("disabled pwm", {31'b0, pwm_out}, 32'd0);
        rd_chk("disabled status", 12'd10, 32'h0000_0028);
        rd_chk("disabled ctrl", 12'd9, 32'd0);

        // Re-enable: fresh period from us_cnt 0, pulse rises one clock later.
        @(negedge clk);
        wr(12'd9, 32'd1);
        chk("reenable pwm edge", {31'b0, pwm_out}, 32'd0);
        chk("reenable us_cnt", {16'b0, dut.us_cnt}, 32'd0);
        chk("reenable busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("reenable pwm rise", {31'b0, pwm_out}, 32'd1);
        w = 1;
        for (int n = 0; n < 1000 && pwm_out; n++) begin
            @(negedge clk);
            if (pwm_out) w++;
        end
        chk("reenable pulse clocks", w, 160);

        // Asynchronous reset in the middle of a pulse.
        wait_rise("pre-reset");
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrun reset pwm", {31'b0, pwm_out}, 32'd0);
        chk("midrun reset busy", {31'b0, busy}, 32'd0);
        rd_chk("midrun reset status", 12'd10, 32'h0000_001E);
        rd_chk("midrun reset ctrl", 12'd9, 32'd0);
        rd_chk("midrun reset target", 12'd8, 32'd30);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("post reset pwm", {31'b0, pwm_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
